layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//  Initiator side of the compute start/done handshake: walks a programmed list of layer ops
//  (conv/dense/pool) and, per layer, requests a config load, then drives comp_sel and a 1-cycle
//  start_comp pulse, holds comp_sel stable and waits for done before advancing.
//  Sits between the host/regfile control plane and the computation controller; one network pass per go.
// PARAMETERS
//  MAX_LAYERS  16  depth of descriptor table; LW = $clog2(MAX_LAYERS)
//  WDOG_W      20  watchdog counter width (used only when LAYER_SEQ_WATCHDOG_EN is defined)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  desc_we     in   1   descriptor write strobe (ignored while busy)
//  desc_waddr  in   LW  descriptor index
//  desc_wdata  in   3   layer op: 3'b001 conv, 3'b010 dense, 3'b011 pool; others illegal
//  num_layers  in   LW+1 layers to run this pass (0..MAX_LAYERS), sampled on go
//  go          in   1   start pass (accepted only in IDLE or ERR)
//  abort       in   1   return to IDLE next cycle, any state
//  cfg_req     out  1   level; requests per-layer register load for cfg_layer
//  cfg_layer   out  LW  layer index being configured/run
//  cfg_ack     in   1   1-cycle ack of cfg_req
//  comp_sel    out  3   op select to computation controller; 3'b000 when not running a layer
//  start_comp  out  1   1-cycle start pulse
//  done        in   1   layer complete (level or pulse; first high cycle in WAIT is taken)
//  busy        out  1   high in any state except IDLE/ERR
//  pass_done   out  1   1-cycle pulse when the last layer completes
//  err         out  1   sticky; cleared by go or rst
//  err_code    out  2   2'd1 illegal op, 2'd2 watchdog timeout, 2'd0 none
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, layer index 0; descriptor contents undefined.
//  - FSM: IDLE -go-> (num_layers==0 ? FIN : CFG); CFG: cfg_req=1 until cfg_ack; op check ->
//    illegal ? ERR : START; START: start_comp=1 one cycle, comp_sel=op -> WAIT; WAIT: comp_sel=op
//    held, on done -> (last ? FIN : NEXT); NEXT: idx+1 -> CFG; FIN: pass_done=1 -> IDLE.
//  - comp_sel registered, changes only on CFG->START entry and on leaving WAIT (to 0).
//  - done ignored outside WAIT (incl. the START cycle); cfg_ack ignored outside CFG.
//  - Latency: go to first start_comp = 2 cycles + cfg_ack delay; done to next cfg_req = 2 cycles.
//  - num_layers>MAX_LAYERS clamped to MAX_LAYERS. num_layers==0: pass_done 2 cycles after go, no start.
//  - go while busy ignored; go in ERR clears err/err_code and starts a new pass.
//  - abort wins over all same-cycle events: next cycle IDLE, comp_sel=0, cfg_req=0, no pass_done;
//    engine is not waited on. abort+go same cycle: abort wins.
//  - desc_we with desc_waddr>=MAX_LAYERS dropped. Write and read of same index in same cycle: old data.
// CONFIGURATION
//  LAYER_SEQ_WATCHDOG_EN defined: WDOG_W counter cleared on WAIT entry, increments each WAIT cycle;
//   at all-ones without done -> ERR, err=1, err_code=2'd2, comp_sel=0.
//  Not defined: WAIT waits indefinitely; err_code 2'd2 never produced; no counter logic.
// STRUCTURE
//  Package layer_seq_pkg: comp_op_e enum (NONE/CONV/DENSE/POOL = 0..3), seq_state_e enum,
//   err_code constants, op_legal() function.
//  Sub-module layer_desc_table: MAX_LAYERS x 3 register file, 1 write port, 1 async read port.
// TESTING
//  1. desc={conv,pool,dense}, num_layers=3, go, cfg_ack 1 cycle after req, done 5 cycles after
//     each start -> comp_sel 1,3,2 in order, 3 start pulses, one pass_done, busy low after.
//  2. num_layers=0, go -> pass_done 2 cycles later, start_comp never high.
//  3. desc[1]=3'b101, num_layers=2 -> layer 0 runs, then err=1, err_code=1, no 2nd start; go clears err.
//  4. done held high during START and during IDLE -> ignored; only WAIT done advances.
//  5. abort asserted in WAIT with done same cycle -> IDLE next cycle, no pass_done, comp_sel=0.
//  6. WATCHDOG_EN, WDOG_W=4, done never -> ERR after 15 WAIT cycles, err_code=2; async rst mid-WAIT clears all.

Source files
------------

// File: rtl/layer_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : layer_seq_pkg
//  Description : Shared types, error codes and the op legality check for the
//                layer sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package layer_seq_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_CONV  = 3'd1,
        OP_DENSE = 3'd2,
        OP_POOL  = 3'd3
    } comp_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CFG   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4,
        S_FIN   = 3'd5,
        S_ERR   = 3'd6
    } seq_state_e;

    localparam logic [1:0] C_ERR_NONE       = 2'd0;
    localparam logic [1:0] C_ERR_ILLEGAL_OP = 2'd1;
    localparam logic [1:0] C_ERR_WDOG       = 2'd2;

    // Only the three engine ops may be issued; everything else aborts the pass.
    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_CONV) || (op == OP_DENSE) || (op == OP_POOL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_desc_table.sv
`default_nettype none
// ============================================================================
//  Module      : layer_desc_table
//  Description : MAX_LAYERS x 3-bit descriptor register file, one write port
//                and one asynchronous read port (same-cycle read sees old data).
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_desc_table #(
    parameter int MAX_LAYERS = 16,
    parameter int LW         = $clog2(MAX_LAYERS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [LW-1:0] waddr,
    input  logic [2:0]    wdata,
    input  logic [LW-1:0] raddr,
    output logic [2:0]    rdata
);

    localparam logic [LW:0] C_DEPTH = (LW+1)'(MAX_LAYERS);

    logic [2:0] r_mem [MAX_LAYERS];

    // Write port; indices beyond the table depth are dropped. No reset: contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < C_DEPTH)) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < C_DEPTH) ? r_mem[raddr] : 3'b000;

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : layer_sequencer
//  Description : Walks the descriptor table once per go: config request,
//                start pulse, wait for done, advance. Optional WAIT watchdog
//                is enabled by defining LAYER_SEQ_WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int MAX_LAYERS = 16,
    parameter int WDOG_W     = 20,
    localparam int LW        = $clog2(MAX_LAYERS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          desc_we,
    input  logic [LW-1:0] desc_waddr,
    input  logic [2:0]    desc_wdata,
    input  logic [LW:0]   num_layers,
    input  logic          go,
    input  logic          abort,
    output logic          cfg_req,
    output logic [LW-1:0] cfg_layer,
    input  logic          cfg_ack,
    output logic [2:0]    comp_sel,
    output logic          start_comp,
    input  logic          done,
    output logic          busy,
    output logic          pass_done,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam logic [LW:0] C_MAX_NL = (LW+1)'(MAX_LAYERS);

    seq_state_e    r_state;
    seq_state_e    w_state_next;
    logic [LW-1:0] r_idx;
    logic [LW:0]   r_nl;
    comp_op_e      r_comp_sel;
    logic          r_err;
    logic [1:0]    r_err_code;
    logic          r_pass_done;

    logic [2:0]    w_op;
    logic [LW:0]   w_nl_clamped;
    logic          w_go_ok;
    logic          w_last;
    logic          w_cfg_done;
    logic          w_wdog_expire;

    layer_desc_table #(
        .MAX_LAYERS (MAX_LAYERS),
        .LW         (LW)
    ) u_desc (
        .clk   (clk),
        .we    (desc_we && !busy),
        .waddr (desc_waddr),
        .wdata (desc_wdata),
        .raddr (r_idx),
        .rdata (w_op)
    );

    assign w_nl_clamped = (num_layers > C_MAX_NL) ? C_MAX_NL : num_layers;
    assign w_go_ok      = go && !abort && ((r_state == S_IDLE) || (r_state == S_ERR));
    assign w_last       = (({1'b0, r_idx} + (LW+1)'(1)) == r_nl);
    assign w_cfg_done   = (r_state == S_CFG) && cfg_ack && !abort;

`ifdef LAYER_SEQ_WATCHDOG_EN
    logic [WDOG_W-1:0] r_wdog;
    logic [WDOG_W-1:0] w_wdog_inc;

    assign w_wdog_inc    = r_wdog + 1'b1;
    // Fires on the cycle the counter would reach all-ones with the engine still silent.
    assign w_wdog_expire = (r_state == S_WAIT) && !done && (&w_wdog_inc);

    // Watchdog counter: cleared in START so it starts from zero on WAIT entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (r_state == S_START) begin
            r_wdog <= '0;
        end else if (r_state == S_WAIT) begin
            r_wdog <= w_wdog_inc;
        end
    end
`else
    assign w_wdog_expire = 1'b0;
    wire unused_wdog_w = (WDOG_W > 0);
`endif

    // Next-state logic; abort overrides every other same-cycle event.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_ERR: if (go) w_state_next = (w_nl_clamped == '0) ? S_FIN : S_CFG;
            S_CFG:         if (cfg_ack) w_state_next = op_legal(w_op) ? S_START : S_ERR;
            S_START:       w_state_next = S_WAIT;
            S_WAIT: begin
                if (done)               w_state_next = w_last ? S_FIN : S_NEXT;
                else if (w_wdog_expire) w_state_next = S_ERR;
            end
            S_NEXT:        w_state_next = S_CFG;
            S_FIN:         w_state_next = S_IDLE;
            default:       w_state_next = S_IDLE;
        endcase
        if (abort) w_state_next = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Pass bookkeeping: layer count latched on go, index advanced in NEXT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_nl  <= '0;
        end else if (w_go_ok) begin
            r_idx <= '0;
            r_nl  <= w_nl_clamped;
        end else if ((r_state == S_NEXT) && !abort) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Registered op select: loaded on CFG->START, cleared whenever WAIT is left or on abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_comp_sel <= OP_NONE;
        end else if (abort) begin
            r_comp_sel <= OP_NONE;
        end else if (w_cfg_done && op_legal(w_op)) begin
            r_comp_sel <= comp_op_e'(w_op);
        end else if ((r_state == S_WAIT) && (w_state_next != S_WAIT)) begin
            r_comp_sel <= OP_NONE;
        end
    end

    // Sticky error flag and code; an accepted go starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_err_code <= C_ERR_NONE;
        end else if (w_go_ok) begin
            r_err      <= 1'b0;
            r_err_code <= C_ERR_NONE;
        end else if (w_cfg_done && !op_legal(w_op)) begin
            r_err      <= 1'b1;
            r_err_code <= C_ERR_ILLEGAL_OP;
        end else if (w_wdog_expire && !abort) begin
            r_err      <= 1'b1;
            r_err_code <= C_ERR_WDOG;
        end
    end

    // Pass-complete pulse, registered off FIN so an abort in FIN suppresses it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pass_done <= 1'b0;
        else     r_pass_done <= (r_state == S_FIN) && !abort;
    end

    assign cfg_req    = (r_state == S_CFG);
    assign cfg_layer  = r_idx;
    assign comp_sel   = r_comp_sel;
    assign start_comp = (r_state == S_START);
    assign busy       = (r_state != S_IDLE) && (r_state != S_ERR);
    assign pass_done  = r_pass_done;
    assign err        = r_err;
    assign err_code   = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer_sequencer
//  Description : Self-checking bench for layer_sequencer with randomized
//                descriptor tables and handshake timing, compared against a
//                list-level model of one network pass.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;

    localparam int MAX = 16;
    localparam int LW  = $clog2(MAX);
`ifdef LAYER_SEQ_WATCHDOG_EN
    localparam int TB_WDOG = 4;
`else
    localparam int TB_WDOG = 20;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          desc_we;
    logic [LW-1:0] desc_waddr;
    logic [2:0]    desc_wdata;
    logic [LW:0]   num_layers;
    logic          go;
    logic          abort;
    logic          cfg_req;
    logic [LW-1:0] cfg_layer;
    logic          cfg_ack;
    logic [2:0]    comp_sel;
    logic          start_comp;
    logic          done;
    logic          busy;
    logic          pass_done;
    logic          err;
    logic [1:0]    err_code;

    int vectors    = 0;
    int miscompares = 0;

    logic [2:0] model_desc [MAX];
    int obs_ops[$];
    int obs_layers[$];
    int obs_start_k[$];
    int obs_pass;
    int obs_pass_k;

    always #5 clk = ~clk;

    layer_sequencer #(.MAX_LAYERS(MAX), .WDOG_W(TB_WDOG)) dut (
        .clk        (clk),
        .rst        (rst),
        .desc_we    (desc_we),
        .desc_waddr (desc_waddr),
        .desc_wdata (desc_wdata),
        .num_layers (num_layers),
        .go         (go),
        .abort      (abort),
        .cfg_req    (cfg_req),
        .cfg_layer  (cfg_layer),
        .cfg_ack    (cfg_ack),
        .comp_sel   (comp_sel),
        .start_comp (start_comp),
        .done       (done),
        .busy       (busy),
        .pass_done  (pass_done),
        .err        (err),
        .err_code   (err_code)
    );

    task automatic write_desc(input int idx, input logic [2:0] op);
        @(negedge clk);
        desc_we    = 1'b1;
        desc_waddr = idx[LW-1:0];
        desc_wdata = op;
        @(negedge clk);
        desc_we    = 1'b0;
        model_desc[idx] = op;
    endtask

    // Runs one pass with random handshake timing, then checks it against the list model.
    task automatic run_pass(input int nl, input int amin, input int amax, input int dmin, input int dmax);
        int  ack_wait;
        int  done_wait;
        bit  fin;
        int  nlc;
        int  exp_ops[$];
        bit  exp_err;
        obs_ops.delete(); obs_layers.delete(); obs_start_k.delete();
        obs_pass = 0; obs_pass_k = -1; fin = 1'b0; ack_wait = -1; done_wait = 0;
        @(negedge clk);
        num_layers = nl[LW:0];
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int k = 1; k <= 3000 && !fin; k++) begin
            cfg_ack = 1'b0;
            done    = 1'b0;
            if (done_wait > 0) begin
                done_wait--;
                if (done_wait == 0) done = 1'b1;
            end
            if (start_comp) begin
                obs_ops.push_back(int'(comp_sel));
                obs_layers.push_back(int'(cfg_layer));
                obs_start_k.push_back(k);
                done_wait = int'($urandom_range(dmax, dmin));
            end
            if (cfg_req) begin
                if (ack_wait < 0) ack_wait = int'($urandom_range(amax, amin));
                if (ack_wait == 0) begin
                    cfg_ack  = 1'b1;
                    ack_wait = -1;
                end else begin
                    ack_wait--;
                end
            end
            if (pass_done) begin
                obs_pass++;
                obs_pass_k = k;
            end
            if (!busy) fin = 1'b1;
            else @(negedge clk);
        end
        cfg_ack = 1'b0;
        done    = 1'b0;

        nlc = (nl > MAX) ? MAX : nl;
        exp_err = 1'b0;
        for (int i = 0; i < nlc; i++) begin
            if (model_desc[i] inside {3'd1, 3'd2, 3'd3}) exp_ops.push_back(int'(model_desc[i]));
            else begin
                exp_err = 1'b1;
                break;
            end
        end

        vectors++;
        if (!fin) begin miscompares++; $display("FAIL pass_timeout nl=%0d: busy never dropped, required idle", nl); end
        vectors++;
        if (obs_ops.size() !== exp_ops.size()) begin
            miscompares++;
            $display("FAIL start_count nl=%0d: got %0d starts, required %0d", nl, obs_ops.size(), exp_ops.size());
        end else begin
            for (int i = 0; i < exp_ops.size(); i++) begin
                vectors++;
                if (obs_ops[i] !== exp_ops[i] || obs_layers[i] !== i) begin
                    miscompares++;
                    $display("FAIL layer_op[%0d]: got op %0d layer %0d, required op %0d layer %0d", i, obs_ops[i], obs_layers[i], exp_ops[i], i);
                end
            end
        end
        vectors++;
        if (obs_pass !== (exp_err ? 0 : 1) || err !== exp_err || err_code !== (exp_err ? 2'd1 : 2'd0) || comp_sel !== 3'd0) begin
            miscompares++;
            $display("FAIL pass_outcome nl=%0d: got pass_done=%0d err=%0d code=%0d sel=%0d, required pass_done=%0d err=%0d code=%0d sel=0",
                     nl, obs_pass, err, err_code, comp_sel, exp_err ? 0 : 1, exp_err, exp_err ? 1 : 0);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; desc_we = 1'b0; desc_waddr = '0; desc_wdata = '0; num_layers = '0;
        go = 1'b0; abort = 1'b0; cfg_ack = 1'b0; done = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cfg_req, cfg_layer, comp_sel, start_comp, busy, pass_done, err, err_code} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, required all zero", {cfg_req, cfg_layer, comp_sel, start_comp, busy, pass_done, err, err_code});
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cfg_req, comp_sel, start_comp, busy, pass_done, err} !== '0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %b, required all zero", {cfg_req, comp_sel, start_comp, busy, pass_done, err});
        end
    endtask

    task automatic test_three_layer;
        write_desc(0, 3'd1);
        write_desc(1, 3'd3);
        write_desc(2, 3'd2);
        run_pass(3, 1, 1, 5, 5);
        // ack one cycle after request, done five cycles after start:
        // first start = 2+1, spacing = done + 2 + ack + 1, pass_done = last start + done + 2.
        vectors++;
        if (obs_start_k.size() != 3 || obs_start_k[0] !== 3 || obs_start_k[1] !== 12 || obs_start_k[2] !== 21 || obs_pass_k !== 28) begin
            miscompares++;
            $display("FAIL three_layer_timing: got %0d starts, pass_done at cycle %0d, required starts at 3,12,21 and pass_done at 28",
                     obs_start_k.size(), obs_pass_k);
        end
    endtask

    task automatic test_zero_layers;
        run_pass(0, 0, 0, 1, 1);
        vectors++;
        if (obs_pass_k !== 2 || obs_start_k.size() != 0) begin
            miscompares++;
            $display("FAIL zero_layers: got pass_done at cycle %0d with %0d starts, required cycle 2 with 0 starts", obs_pass_k, obs_start_k.size());
        end
    endtask

    task automatic test_illegal_op;
        write_desc(0, 3'd1);
        write_desc(1, 3'b101);
        run_pass(2, 0, 2, 1, 4);
        @(negedge clk);
        num_layers = '0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        vectors++;
        if (err !== 1'b0 || err_code !== 2'd0) begin
            miscompares++;
            $display("FAIL go_clears_err: got err=%0d code=%0d, required 0/0", err, err_code);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_done_ignored;
        write_desc(0, 3'd3);
        @(negedge clk);
        done = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || start_comp !== 1'b0 || pass_done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_in_idle: got busy=%0d start=%0d pass_done=%0d, required 0/0/0", busy, start_comp, pass_done);
        end
        num_layers = 1;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cfg_ack = cfg_req;
        @(negedge clk);
        cfg_ack = 1'b0;
        vectors++;
        if (start_comp !== 1'b1 || comp_sel !== 3'd3) begin
            miscompares++;
            $display("FAIL start_pulse: got start=%0d sel=%0d, required 1/3", start_comp, comp_sel);
        end
        @(negedge clk);
        done = 1'b0;
        repeat (3) begin
            vectors++;
            if (busy !== 1'b1 || comp_sel !== 3'd3 || start_comp !== 1'b0) begin
                miscompares++;
                $display("FAIL done_in_start: got busy=%0d sel=%0d start=%0d, required 1/3/0", busy, comp_sel, start_comp);
            end
            @(negedge clk);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        vectors++;
        if (pass_done !== 1'b1 || comp_sel !== 3'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_in_wait: got pass_done=%0d sel=%0d busy=%0d, required 1/0/0", pass_done, comp_sel, busy);
        end
    endtask

    task automatic test_abort;
        write_desc(0, 3'd1);
        @(negedge clk);
        num_layers = 1;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cfg_ack = 1'b1;
        @(negedge clk);
        cfg_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || comp_sel !== 3'd1) begin
            miscompares++;
            $display("FAIL abort_setup: got busy=%0d sel=%0d, required 1/1", busy, comp_sel);
        end
        abort = 1'b1;
        done  = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        done  = 1'b0;
        vectors++;
        if (busy !== 1'b0 || comp_sel !== 3'd0 || cfg_req !== 1'b0 || pass_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_in_wait: got busy=%0d sel=%0d req=%0d pass_done=%0d, required all 0", busy, comp_sel, cfg_req, pass_done);
        end
        @(negedge clk);
        vectors++;
        if (pass_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_pass_done: got pass_done=%0d busy=%0d, required 0/0", pass_done, busy);
        end
        abort = 1'b1;
        go    = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        go    = 1'b0;
        vectors++;
        if (busy !== 1'b0 || cfg_req !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_beats_go: got busy=%0d req=%0d, required 0/0", busy, cfg_req);
        end
    endtask

    task automatic test_random_passes;
        int v;
        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < MAX; i++) begin
                if ($urandom_range(15, 0) == 0) begin
                    v = int'($urandom_range(4, 0));
                    write_desc(i, (v == 0) ? 3'd0 : 3'(v + 3));
                end else begin
                    write_desc(i, 3'($urandom_range(3, 1)));
                end
            end
            run_pass(int'($urandom_range(MAX + 3, 0)), 0, 3, 1, 6);
        end
    endtask

`ifdef LAYER_SEQ_WATCHDOG_EN
    task automatic test_watchdog;
        int waits;
        bit seen;
        write_desc(0, 3'd2);
        @(negedge clk);
        num_layers = 1;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cfg_ack = 1'b1;
        @(negedge clk);
        cfg_ack = 1'b0;
        waits = 0;
        seen  = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (err) seen = 1'b1;
            else if (busy) waits++;
        end
        vectors++;
        if (!seen || waits !== 15 || err_code !== 2'd2 || comp_sel !== 3'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL watchdog: got err=%0d after %0d wait cycles code=%0d sel=%0d, required err=1 after 15 code=2 sel=0",
                     seen, waits, err_code, comp_sel);
        end
        num_layers = 1;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cfg_ack = 1'b1;
        @(negedge clk);
        cfg_ack = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({cfg_req, cfg_layer, comp_sel, start_comp, busy, pass_done, err, err_code} !== '0) begin
            miscompares++;
            $display("FAIL async_reset_mid_wait: got %b, required all zero", {cfg_req, cfg_layer, comp_sel, start_comp, busy, pass_done, err, err_code});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_three_layer();
        test_zero_layers();
        test_illegal_op();
        test_done_ignored();
        test_abort();
        test_random_passes();
`ifdef LAYER_SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
